// File: rtl/column_move_collector.sv
// column_move_collector
//   Drains NSRC per-square move FIFOs of one column into a single output
//   FIFO feeding the board-level move gatherer. A source becomes eligible
//   once it reports done; the collector selects one eligible source
//   (fixed priority or round-robin), copies its moves one per cycle until
//   it runs empty, marks it served, and moves on. Once every source is
//   served, done rises and stays high until reset.
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   src_done       per-source "finished generating" flags
//   src_empty      per-source FIFO empty flags
//   src_data       per-source head words, source i at [i*MW +: MW]
//   src_rden       per-source pop strobes (one-hot or zero, combinational)
//   fifoOut        output FIFO head word (show-ahead)
//   fifoEmpty      output FIFO empty
//   fifoFull       output FIFO holds DEPTH entries
//   rden           pop output FIFO head
//   done           all sources served and drained
//   move_count     saturating count of moves written since reset

// Per-source lane: served flag, eligibility and the pop strobe.
module column_move_lane #(
  parameter int SW  = 3,
  parameter int IDX = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          getm,
  input  logic [SW-1:0] sel,
  input  logic          src_done,
  input  logic          src_empty,
  input  logic          full,
  output logic          rden,
  output logic          eligible,
  output logic          served
);
  logic hit;

  assign hit      = getm && (sel == SW'(IDX));
  // Gated by reset so no pop escapes while the collector is being cleared.
  assign rden     = hit && !src_empty && !full && !reset;
  assign eligible = src_done && !served;

  always_ff @(posedge clk) begin
    if (reset)                 served <= 1'b0;
    else if (hit && src_empty) served <= 1'b1;
  end
endmodule

module column_move_collector #(
  parameter int NSRC     = 8,
  parameter int MW       = 160,
  parameter int DEPTH    = 64,
  parameter int ARB_MODE = 0,
  parameter int CW       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   src_done,
  input  logic [NSRC-1:0]   src_empty,
  input  logic [NSRC*MW-1:0] src_data,
  output logic [NSRC-1:0]   src_rden,
  output logic [MW-1:0]     fifoOut,
  output logic              fifoEmpty,
  output logic              fifoFull,
  input  logic              rden,
  output logic              done,
  output logic [CW-1:0]     move_count
);
  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {WAIT, GETM, DONE} state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   sel, sel_nx, rr_ptr, pick;
  logic            found, in_getm;
  logic [NSRC-1:0] eligible, served;

  assign in_getm = (state == GETM);

  // ---------------- lanes ----------------
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_lane
    column_move_lane #(.SW(SW), .IDX(gi)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .getm      (in_getm),
      .sel       (sel),
      .src_done  (src_done[gi]),
      .src_empty (src_empty[gi]),
      .full      (fifoFull),
      .rden      (src_rden[gi]),
      .eligible  (eligible[gi]),
      .served    (served[gi])
    );
  end

  // ---------------- arbitration ----------------
  // Round-robin starts one past the last served source, so rr_ptr resets to
  // NSRC-1 to make index 0 the first candidate.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    if (ARB_MODE == 0) begin
      for (int i = NSRC - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          pick  = SW'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= NSRC; k++) begin
        logic [SW-1:0] j;
        j = SW'((int'(rr_ptr) + k) % NSRC);
        if (!found && eligible[j]) begin
          pick  = j;
          found = 1'b1;
        end
      end
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    case (state)
      WAIT: begin
        if (&served) state_nx = DONE;
        else if (found) begin
          sel_nx   = pick;
          state_nx = GETM;
        end
      end
      GETM:    if (src_empty[sel]) state_nx = WAIT;
      DONE:    state_nx = DONE;
      default: state_nx = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= WAIT;
      sel    <= '0;
      rr_ptr <= SW'(NSRC - 1);
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      if (in_getm && src_empty[sel]) rr_ptr <= sel;
    end
  end

  assign done = (state == DONE);

  // ---------------- output FIFO ----------------
  logic [MW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          wr, rd;

  // src_rden already excludes the full case, so a write never lands on a
  // full FIFO even when the same cycle pops it.
  assign wr        = |src_rden;
  assign rd        = rden && !fifoEmpty;
  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == (AW+1)'(DEPTH));
  assign fifoOut   = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= src_data[int'(sel)*MW +: MW];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      move_count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr && (move_count != '1)) move_count <= move_count + 1'b1;
    end
  end
endmodule
